// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO plus enable/done handshake controller that sits directly in
//   front of the UART transmit serializer. System-side writes are buffered.
//   Each buffered byte is presented to the serializer exactly once, and the
//   bytes go out back to back.
//
// Ports
//   clk          system clock (shared with the serializer)
//   rst          asynchronous, active-high reset
//   wr_en        write strobe, one byte per cycle
//   wr_data      byte to enqueue
//   full         FIFO holds 2**ADDR_W bytes
//   empty        FIFO holds no bytes
//   count        FIFO occupancy, 0..2**ADDR_W
//   overflow     one-cycle pulse after a dropped write
//   send_enable  serializer enable, held until send_done is seen
//   send_data    byte to the serializer, stable while send_enable=1
//   send_done    serializer done, high throughout the stop bit
//   busy         controller not idle or FIFO non-empty
module uart_tx_feeder #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              send_enable,
    output logic [DATA_W-1:0] send_data,
    input  logic              send_done,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_d;
    logic                overflow_q;
    logic                send_enable_q;
    logic [DATA_W-1:0]   send_data_q;

    logic pop;
    logic push;
    logic drop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // A pop frees a slot on the same edge, so a write at full is still
    // accepted when the controller is taking the head byte.
    always_comb begin
        pop  = (state_q == IDLE) && !empty;
        push = wr_en && (!full || pop);
        drop = wr_en && full && !pop;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Storage is not reset; only the pointers and count define valid data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            send_enable_q <= 1'b0;
            send_data_q   <= '0;
        end else begin
            count_q    <= count_d;
            overflow_q <= drop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        send_data_q   <= mem_q[rd_ptr_q];
                        send_enable_q <= 1'b1;
                        state_q       <= ARM;
                    end
                end
                ARM: begin
                    if (send_done) begin
                        send_enable_q <= 1'b0;
                        state_q       <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait for the serializer to leave its stop bit so the
                    // same frame's done is not taken as the next handshake.
                    if (!send_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    send_enable_q <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign count       = count_q;
    assign overflow    = overflow_q;
    assign send_enable = send_enable_q;
    assign send_data   = send_data_q;
    assign busy        = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       full, empty, overflow, send_enable, busy;
    logic [2:0] count;
    logic [7:0] send_data;
    logic       send_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.ADDR_W(2), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .send_enable(send_enable),
        .send_data  (send_data),
        .send_done  (send_done),
        .busy       (busy)
    );

    // Serializer model: baud tick every 4 clocks, samples enable on a tick,
    // sends start, 8 data bits LSB first, stop; done high during stop bit.
    logic [7:0]  sent_q [$];
    logic        txbits [$];
    logic [9:0]  frame;
    int unsigned bit_idx;
    int unsigned div;
    logic        ser_busy;
    logic        ser_done;
    logic        tx;
    bit          hold_stop = 1'b0;

    assign send_done = ser_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= 0;
            bit_idx  <= 0;
            ser_busy <= 1'b0;
            ser_done <= 1'b0;
            tx       <= 1'b1;
            frame    <= '0;
        end else begin
            div <= (div == 3) ? 0 : div + 1;
            if (div == 3) begin
                if (!ser_busy) begin
                    if (send_enable) begin
                        frame    <= {1'b1, send_data, 1'b0};
                        tx       <= 1'b0;
                        txbits.push_back(1'b0);
                        sent_q.push_back(send_data);
                        bit_idx  <= 1;
                        ser_busy <= 1'b1;
                    end
                end else if (bit_idx < 10) begin
                    tx <= frame[bit_idx];
                    txbits.push_back(frame[bit_idx]);
                    if (bit_idx == 9) ser_done <= 1'b1;
                    bit_idx <= bit_idx + 1;
                end else if (!hold_stop) begin
                    ser_done <= 1'b0;
                    ser_busy <= 1'b0;
                    tx       <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_done_level(input logic lvl, input string tag);
        int n = 0;
        while (send_done !== lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check(tag, 32'(send_done), 32'(lvl));
    endtask

    task automatic wait_drain(input int n, input string tag);
        int c = 0;
        while (!(sent_q.size() >= n && !busy && !send_done) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 2000) check(tag, 32'(sent_q.size()), 32'(n));
    endtask

    logic [7:0] exp_q [$];
    logic [9:0] bits;
    int         peak;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_en", 32'(send_enable), 0);
        check("rst_data", 32'(send_data), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: latency, frame bits, handshake
        sent_q.delete();
        txbits.delete();
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        check("single_cnt1", 32'(count), 1);
        check("single_en_early", 32'(send_enable), 0);
        @(negedge clk);
        check("single_en", 32'(send_enable), 1);
        check("single_data", 32'(send_data), 32'hA5);
        check("single_cnt0", 32'(count), 0);
        wait_done_level(1'b1, "single_done_rise_tmo");
        check("single_en_hold", 32'(send_enable), 1);
        @(negedge clk);
        check("single_en_fall", 32'(send_enable), 0);
        wait_done_level(1'b0, "single_done_fall_tmo");
        @(negedge clk);
        check("single_busy", 32'(busy), 0);
        check("single_nbits", 32'(txbits.size()), 10);
        bits = '0;
        for (int i = 0; i < 10 && i < txbits.size(); i++) bits[i] = txbits[i];
        check("single_frame", 32'(bits), 32'h34A);
        check("single_sent", 32'(sent_q.size()), 1);

        // Burst of four
        sent_q.delete();
        peak = 0;
        for (int i = 1; i <= 4; i++) begin
            write_byte(8'(i));
            if (int'(count) > peak) peak = int'(count);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
        end
        check("burst_peak", 32'(peak), 3);
        wait_drain(4, "burst_drain_tmo");
        check("burst_n", 32'(sent_q.size()), 4);
        for (int i = 0; i < 4 && i < sent_q.size(); i++)
            check($sformatf("burst_b%0d", i), 32'(sent_q[i]), 32'(i + 1));

        // Full / overflow with the serializer held in its stop bit
        sent_q.delete();
        hold_stop = 1'b1;
        write_byte(8'h30);
        wait_done_level(1'b1, "ovf_done_tmo");
        for (int i = 1; i <= 4; i++) write_byte(8'(8'h30 + i));
        check("ovf_full", 32'(full), 1);
        check("ovf_cnt4", 32'(count), 4);
        check("ovf_pre", 32'(overflow), 0);
        wr_en = 1'b1; wr_data = 8'h35;
        @(negedge clk);
        wr_en = 1'b0;
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_cnt", 32'(count), 4);
        @(negedge clk);
        check("ovf_clear", 32'(overflow), 0);

        // Write at full on the same edge as the pop
        hold_stop = 1'b0;
        wait_done_level(1'b0, "wp_done_fall_tmo");
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h7E;
        @(negedge clk);
        wr_en = 1'b0;
        check("wp_cnt", 32'(count), 4);
        check("wp_ovf", 32'(overflow), 0);
        check("wp_en", 32'(send_enable), 1);
        check("wp_data", 32'(send_data), 32'h31);
        wait_drain(6, "wp_drain_tmo");
        exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h7E};
        check("wp_n", 32'(sent_q.size()), 6);
        for (int i = 0; i < 6 && i < sent_q.size(); i++)
            check($sformatf("wp_b%0d", i), 32'(sent_q[i]), 32'(exp_q[i]));

        // Pointer wrap: ten bytes through a four-entry FIFO
        sent_q.delete();
        for (int i = 0; i < 10; i++) begin
            int n = 0;
            while (full && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (n >= 400) check("wrap_full_tmo", 32'(full), 0);
            write_byte(8'(8'h10 + i));
        end
        wait_drain(10, "wrap_drain_tmo");
        check("wrap_n", 32'(sent_q.size()), 10);
        for (int i = 0; i < 10 && i < sent_q.size(); i++)
            check($sformatf("wrap_b%0d", i), 32'(sent_q[i]), 32'(8'h10 + i));
        check("wrap_empty", 32'(empty), 1);
        check("wrap_cnt", 32'(count), 0);

        // Reset mid-ARM with three bytes queued
        for (int i = 0; i < 4; i++) write_byte(8'(8'h50 + i));
        check("mrst_pre_cnt", 32'(count), 3);
        check("mrst_pre_en", 32'(send_enable), 1);
        rst = 1'b1;
        #1;
        check("mrst_cnt", 32'(count), 0);
        check("mrst_empty", 32'(empty), 1);
        check("mrst_en", 32'(send_enable), 0);
        check("mrst_data", 32'(send_data), 0);
        @(negedge clk);
        rst = 1'b0;
        sent_q.delete();
        repeat (200) @(negedge clk);
        check("mrst_sent", 32'(sent_q.size()), 0);
        check("mrst_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
